// File: rtl/cmp_operand_gen.sv
// cmp_operand_gen: operand-pair stimulus source for the compare tester.
// Emits 8 directed corner-case pairs followed by NUM_RANDOM pairs drawn from
// two Galois LFSRs, over a valid/ready handshake, then raises a sticky done.
//
// Ports:
//   clk        master clock, rising edge
//   rst        asynchronous active-high reset
//   enable     permits launching the next pair
//   out_valid  out_a/out_b/out_index hold a valid pair
//   out_ready  consumer accepts the presented pair this cycle
//   out_a      first operand  (WIDTH bits)
//   out_b      second operand (WIDTH bits)
//   out_index  0-based sequence number of the presented pair
//   done       sticky, set when the final pair has been accepted
module cmp_operand_gen #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned NUM_RANDOM = 256,
  parameter logic [31:0] SEED       = 32'h0000_0001
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_a,
  output logic [WIDTH-1:0] out_b,
  output logic [15:0]      out_index,
  output logic             done
);

  localparam int unsigned IDX_W      = 16;
  localparam int unsigned NUM_CORNER = 8;
  localparam int unsigned LFSR_W     = 32;

  localparam logic [IDX_W-1:0]  LAST_IDX    = IDX_W'(NUM_CORNER + NUM_RANDOM - 1);
  localparam logic [IDX_W-1:0]  LAST_CORNER = IDX_W'(NUM_CORNER - 1);
  localparam logic [IDX_W-1:0]  CORNER_CNT  = IDX_W'(NUM_CORNER);
  localparam logic [LFSR_W-1:0] LFSR_MASK   = 32'h8020_0003;
  // An all-zero seed would lock the LFSR, so it is promoted to 1.
  localparam logic [LFSR_W-1:0] SEED_EFF    = (SEED == 32'd0) ? 32'd1 : SEED;

  localparam logic [WIDTH-1:0] ZERO     = '0;
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] HALF     = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] HALF_M1  = {1'b0, {(WIDTH-1){1'b1}}};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CORNER = 2'd1,
    RANDOM = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t             state;
  logic [IDX_W-1:0]   next_idx;   // index of the next pair to be presented
  logic [LFSR_W-1:0]  lfsr_a;     // value for the next random pair, operand A
  logic [LFSR_W-1:0]  lfsr_b;     // value for the next random pair, operand B

  logic               xfer_c;
  logic               last_c;
  logic               launch_c;
  logic               is_corner_c;
  logic [WIDTH-1:0]   pair_a_c;
  logic [WIDTH-1:0]   pair_b_c;

  // Galois right-shift step.
  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_MASK : '0);
  endfunction

  // Handshake decode and launch decision.
  always_comb begin
    xfer_c   = out_valid && out_ready;
    last_c   = (out_index == LAST_IDX);
    launch_c = 1'b0;
    unique case (state)
      IDLE:           launch_c = enable;
      CORNER, RANDOM: launch_c = enable && (!out_valid || (xfer_c && !last_c));
      default:        launch_c = 1'b0;
    endcase
  end

  // Pair selected by next_idx: corner table first, then the LFSR values.
  always_comb begin
    is_corner_c = (next_idx < CORNER_CNT);
    pair_a_c    = lfsr_a[WIDTH-1:0];
    pair_b_c    = lfsr_b[WIDTH-1:0];
    if (is_corner_c) begin
      unique case (next_idx[2:0])
        3'd0:    begin pair_a_c = ZERO;     pair_b_c = ZERO;     end
        3'd1:    begin pair_a_c = ZERO;     pair_b_c = ONE;      end
        3'd2:    begin pair_a_c = ONE;      pair_b_c = ZERO;     end
        3'd3:    begin pair_a_c = ALL_ONES; pair_b_c = ALL_ONES; end
        3'd4:    begin pair_a_c = ALL_ONES; pair_b_c = ZERO;     end
        3'd5:    begin pair_a_c = ZERO;     pair_b_c = ALL_ONES; end
        3'd6:    begin pair_a_c = HALF;     pair_b_c = HALF_M1;  end
        default: begin pair_a_c = HALF_M1;  pair_b_c = HALF;     end
      endcase
    end
  end

  // Sequencer: phase state, presented pair, index and LFSR advance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      next_idx  <= '0;
      lfsr_a    <= SEED_EFF;
      lfsr_b    <= ~SEED_EFF;
      out_valid <= 1'b0;
      out_a     <= '0;
      out_b     <= '0;
      out_index <= '0;
      done      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (enable) state <= CORNER;
        end
        CORNER, RANDOM: begin
          if (xfer_c && last_c) begin
            state <= DONE;
            done  <= 1'b1;
          end else if (xfer_c && (state == CORNER) && (out_index == LAST_CORNER)) begin
            state <= RANDOM;
          end
          // Valid only drops after a transfer that cannot be followed at once.
          if (xfer_c && !launch_c) out_valid <= 1'b0;
        end
        default: begin
          out_valid <= 1'b0;
          done      <= 1'b1;
        end
      endcase

      if (launch_c) begin
        out_valid <= 1'b1;
        out_a     <= pair_a_c;
        out_b     <= pair_b_c;
        out_index <= next_idx;
        next_idx  <= next_idx + IDX_W'(1);
        // Each presented random pair is eventually accepted, so stepping on
        // presentation matches stepping once per accepted random pair.
        if (!is_corner_c) begin
          lfsr_a <= lfsr_step(lfsr_a);
          lfsr_b <= lfsr_step(lfsr_b);
        end
      end
    end
  end

endmodule

// File: tb/tb_cmp_operand_gen.sv
module tb_cmp_operand_gen;

  localparam int unsigned NR   = 24;
  localparam int unsigned LAST = 7 + NR;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        out_ready = 1'b0;
  logic        out_valid;
  logic [31:0] out_a, out_b;
  logic [15:0] out_index;
  logic        done;

  logic        en2 = 1'b0;
  logic        rdy2 = 1'b0;
  logic        z_valid, z_done;
  logic [7:0]  z_a, z_b;
  logic [15:0] z_index;
  logic        s_valid, s_done;
  logic [15:0] s_a, s_b;
  logic [15:0] s_index;

  always #5 clk = ~clk;

  cmp_operand_gen #(.WIDTH(32), .NUM_RANDOM(NR), .SEED(32'h1)) dut (
    .clk(clk), .rst(rst), .enable(enable), .out_valid(out_valid), .out_ready(out_ready),
    .out_a(out_a), .out_b(out_b), .out_index(out_index), .done(done));

  cmp_operand_gen #(.WIDTH(8), .NUM_RANDOM(0), .SEED(32'h0)) dut_z (
    .clk(clk), .rst(rst), .enable(en2), .out_valid(z_valid), .out_ready(rdy2),
    .out_a(z_a), .out_b(z_b), .out_index(z_index), .done(z_done));

  cmp_operand_gen #(.WIDTH(16), .NUM_RANDOM(2), .SEED(32'h0)) dut_s (
    .clk(clk), .rst(rst), .enable(en2), .out_valid(s_valid), .out_ready(rdy2),
    .out_a(s_a), .out_b(s_b), .out_index(s_index), .done(s_done));

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [15:0] idx;
  } pair_t;

  pair_t exp_q[$];
  int total = 0;
  int bad = 0;
  int run_id = 0;

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: corner table from M/H arithmetic, random pairs by iterating the LFSR rule.
  function automatic void model_pair(input int w, input int idx, input logic [31:0] seed,
                                     output logic [31:0] a, output logic [31:0] b);
    logic [63:0] m64;
    logic [31:0] m, h, sa, sb;
    m64 = (64'd1 << w) - 64'd1;
    m   = m64[31:0];
    h   = 32'd1 << (w - 1);
    case (idx)
      0: begin a = 0;     b = 0;     end
      1: begin a = 0;     b = 1;     end
      2: begin a = 1;     b = 0;     end
      3: begin a = m;     b = m;     end
      4: begin a = m;     b = 0;     end
      5: begin a = 0;     b = m;     end
      6: begin a = h;     b = h - 1; end
      7: begin a = h - 1; b = h;     end
      default: begin
        sa = (seed == 32'd0) ? 32'd1 : seed;
        sb = ~sa;
        for (int k = 8; k < idx; k++) begin
          sa = (sa >> 1) ^ (sa[0] ? 32'h8020_0003 : 32'd0);
          sb = (sb >> 1) ^ (sb[0] ? 32'h8020_0003 : 32'd0);
        end
        a = sa & m;
        b = sb & m;
      end
    endcase
  endfunction

  // Monitor: pops expected pairs on each transfer and checks handshake rules cycle to cycle.
  logic        pv, pr, pe, pd;
  logic [31:0] pa, pb;
  logic [15:0] pi;
  int          seen_run = 0;
  pair_t       e;

  always @(negedge clk) begin
    if (!rst) begin
      if (seen_run != run_id) begin
        seen_run = run_id;
      end else begin
        if (pd) chk("done_hold", {94'd0, done, out_valid}, 96'b10);
        else if (pv && pr) begin
          if (pi == 16'(LAST)) chk("done_rise", {94'd0, done, out_valid}, 96'b10);
          else chk("valid_after_xfer", {94'd0, done, out_valid}, {94'd0, 1'b0, pe});
        end else if (pv)
          chk("stall_hold", {15'd0, out_valid, out_a, out_b, out_index}, {15'd0, 1'b1, pa, pb, pi});
        else chk("launch", {94'd0, done, out_valid}, {94'd0, 1'b0, pe});
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_pair: got index %0d expected none", out_index);
        end else begin
          e = exp_q.pop_front();
          chk("pair", {16'd0, out_a, out_b, out_index}, {16'd0, e.a, e.b, e.idx});
        end
      end
      pv = out_valid; pr = out_ready; pe = enable; pd = done;
      pa = out_a; pb = out_b; pi = out_index;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    logic [31:0] a, b;
    rst = 1'b1;
    enable = 1'b0;
    out_ready = 1'b0;
    en2 = 1'b0;
    rdy2 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    exp_q.delete();
    for (int i = 0; i <= int'(LAST); i++) begin
      model_pair(32, i, 32'h1, a, b);
      exp_q.push_back('{a: a, b: b, idx: 16'(i)});
    end
    run_id++;
    rst = 1'b0;
  endtask

  task automatic run_to_done(input int budget);
    int n;
    n = 0;
    while (!done && n < budget) begin
      out_ready = ($urandom_range(0, 3) != 0);
      enable    = ($urandom_range(0, 5) != 0);
      tick();
      n++;
    end
    chk("finish_in_budget", {95'd0, done}, 96'd1);
    chk("queue_empty", 96'(exp_q.size()), 96'd0);
  endtask

  task automatic wait_idx(input int idx, input bit rnd);
    int n;
    n = 0;
    while (!(out_valid && out_index == 16'(idx)) && n < 500) begin
      if (rnd) begin
        out_ready = ($urandom_range(0, 3) != 0);
        enable    = ($urandom_range(0, 5) != 0);
      end
      tick();
      n++;
    end
    chk("reach_index", {79'd0, out_valid, out_index}, {79'd0, 1'b1, 16'(idx)});
  endtask

  task automatic run_continuous();
    int first, dcyc;
    first = -1;
    dcyc  = -1;
    enable = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 200; c++) begin
      tick();
      if (out_valid && first < 0) first = c;
      if (out_valid) begin
        case (out_index)
          16'd0: chk("idx0_lit", {32'd0, out_a, out_b}, {32'd0, 32'h0, 32'h0});
          16'd6: chk("idx6_lit", {32'd0, out_a, out_b}, {32'd0, 32'h8000_0000, 32'h7FFF_FFFF});
          16'd8: chk("idx8_lit", {32'd0, out_a, out_b}, {32'd0, 32'h0000_0001, 32'hFFFF_FFFE});
          16'd9: chk("idx9_lit", {32'd0, out_a, out_b}, {32'd0, 32'h8020_0003, 32'h7FFF_FFFF});
          default: ;
        endcase
      end
      if (done) begin
        dcyc = c;
        break;
      end
    end
    chk("first_valid_edge", 96'(first), 96'd0);
    chk("done_latency", 96'(dcyc - first), 96'(8 + NR));
    repeat (3) tick();
    chk("idle_after_done", {94'd0, done, out_valid}, 96'b10);
  endtask

  initial begin
    int zf, zd, sf, sd;
    logic [31:0] ma, mb;

    // Continuous run.
    do_reset();
    chk("reset_outputs", {15'd0, out_valid, out_a, out_b, out_index, done}, 96'd0);
    run_continuous();

    // Stall at index 2 with enable dropped, then stall at index 3.
    do_reset();
    enable = 1'b1;
    out_ready = 1'b1;
    wait_idx(2, 1'b0);
    out_ready = 1'b0;
    enable = 1'b0;
    tick();
    tick();
    chk("idx2_held", {79'd0, out_valid, out_index}, {79'd0, 1'b1, 16'd2});
    out_ready = 1'b1;
    tick();
    chk("drop_after_xfer", {95'd0, out_valid}, 96'd0);
    repeat (3) tick();
    chk("still_idle", {95'd0, out_valid}, 96'd0);
    enable = 1'b1;
    tick();
    chk("resume_idx3", {79'd0, out_valid, out_index}, {79'd0, 1'b1, 16'd3});
    out_ready = 1'b0;
    repeat (5) tick();
    chk("idx3_stall", {15'd0, out_valid, out_a, out_b, out_index},
        {15'd0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 16'd3});
    out_ready = 1'b1;
    tick();
    chk("after_stall_idx4", {79'd0, out_valid, out_index}, {79'd0, 1'b1, 16'd4});
    run_to_done(3000);

    // Random handshake up to index 10, stall, then asynchronous reset.
    do_reset();
    wait_idx(10, 1'b1);
    out_ready = 1'b0;
    tick();
    tick();
    #2;
    rst = 1'b1;
    #1;
    chk("async_reset_zero", {15'd0, out_valid, out_a, out_b, out_index, done}, 96'd0);
    do_reset();
    run_continuous();

    // Fully random run.
    do_reset();
    run_to_done(3000);

    // NUM_RANDOM=0 and SEED=0 instances under continuous ready.
    do_reset();
    en2 = 1'b1;
    rdy2 = 1'b1;
    zf = -1; zd = -1; sf = -1; sd = -1;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (z_valid) begin
        if (zf < 0) zf = c;
        model_pair(8, int'(z_index), 32'h0, ma, mb);
        chk("z_pair", {80'd0, z_a, z_b}, {80'd0, ma[7:0], mb[7:0]});
      end
      if (z_done && zd < 0) zd = c;
      if (zd >= 0) chk("z_no_valid_after_done", {94'd0, z_done, z_valid}, 96'b10);
      if (s_valid) begin
        if (sf < 0) sf = c;
        model_pair(16, int'(s_index), 32'h0, ma, mb);
        chk("s_pair", {64'd0, s_a, s_b}, {64'd0, ma[15:0], mb[15:0]});
        if (s_index == 16'd8) chk("s_idx8_lit", {64'd0, s_a, s_b}, {64'd0, 16'h0001, 16'hFFFE});
      end
      if (s_done && sd < 0) sd = c;
    end
    chk("z_first", 96'(zf), 96'd0);
    chk("z_done_latency", 96'(zd - zf), 96'd8);
    chk("s_done_latency", 96'(sd - sf), 96'd10);

    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
